// File: rtl/generic_io_dft_pkg.sv
// Shared types and LFSR helpers for the IO loopback BIST engine.
// Tap table holds maximal-length Fibonacci feedback taps for widths 2..64.
package generic_io_dft_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEED  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_CHECK = 3'd4,
        ST_DONE  = 3'd5
    } bist_state_e;

    function automatic logic [63:0] tap_bits(input int a, input int b, input int c, input int d);
        logic [63:0] r;
        r = '0;
        if (a > 0) r = r | (64'd1 << (a - 1));
        if (b > 0) r = r | (64'd1 << (b - 1));
        if (c > 0) r = r | (64'd1 << (c - 1));
        if (d > 0) r = r | (64'd1 << (d - 1));
        return r;
    endfunction

    // Tap positions are 1-based; the register shifts towards the MSB.
    function automatic logic [63:0] lfsr_taps(input int width);
        case (width)
            2:  return tap_bits(2, 1, 0, 0);
            3:  return tap_bits(3, 2, 0, 0);
            4:  return tap_bits(4, 3, 0, 0);
            5:  return tap_bits(5, 3, 0, 0);
            6:  return tap_bits(6, 5, 0, 0);
            7:  return tap_bits(7, 6, 0, 0);
            8:  return tap_bits(8, 6, 5, 4);
            9:  return tap_bits(9, 5, 0, 0);
            10: return tap_bits(10, 7, 0, 0);
            11: return tap_bits(11, 9, 0, 0);
            12: return tap_bits(12, 6, 4, 1);
            13: return tap_bits(13, 4, 3, 1);
            14: return tap_bits(14, 5, 3, 1);
            15: return tap_bits(15, 14, 0, 0);
            16: return tap_bits(16, 15, 13, 4);
            17: return tap_bits(17, 14, 0, 0);
            18: return tap_bits(18, 11, 0, 0);
            19: return tap_bits(19, 6, 2, 1);
            20: return tap_bits(20, 17, 0, 0);
            21: return tap_bits(21, 19, 0, 0);
            22: return tap_bits(22, 21, 0, 0);
            23: return tap_bits(23, 18, 0, 0);
            24: return tap_bits(24, 23, 22, 17);
            25: return tap_bits(25, 22, 0, 0);
            26: return tap_bits(26, 6, 2, 1);
            27: return tap_bits(27, 5, 2, 1);
            28: return tap_bits(28, 25, 0, 0);
            29: return tap_bits(29, 27, 0, 0);
            30: return tap_bits(30, 6, 4, 1);
            31: return tap_bits(31, 28, 0, 0);
            32: return tap_bits(32, 22, 2, 1);
            33: return tap_bits(33, 20, 0, 0);
            34: return tap_bits(34, 27, 2, 1);
            35: return tap_bits(35, 33, 0, 0);
            36: return tap_bits(36, 25, 0, 0);
            37: return tap_bits(37, 5, 4, 3) | tap_bits(2, 1, 0, 0);
            38: return tap_bits(38, 6, 5, 1);
            39: return tap_bits(39, 35, 0, 0);
            40: return tap_bits(40, 38, 21, 19);
            41: return tap_bits(41, 38, 0, 0);
            42: return tap_bits(42, 41, 20, 19);
            43: return tap_bits(43, 42, 38, 37);
            44: return tap_bits(44, 43, 18, 17);
            45: return tap_bits(45, 44, 42, 41);
            46: return tap_bits(46, 45, 26, 25);
            47: return tap_bits(47, 42, 0, 0);
            48: return tap_bits(48, 47, 21, 20);
            49: return tap_bits(49, 40, 0, 0);
            50: return tap_bits(50, 49, 24, 23);
            51: return tap_bits(51, 50, 36, 35);
            52: return tap_bits(52, 49, 0, 0);
            53: return tap_bits(53, 52, 38, 37);
            54: return tap_bits(54, 53, 18, 17);
            55: return tap_bits(55, 31, 0, 0);
            56: return tap_bits(56, 55, 35, 34);
            57: return tap_bits(57, 50, 0, 0);
            58: return tap_bits(58, 39, 0, 0);
            59: return tap_bits(59, 58, 38, 37);
            60: return tap_bits(60, 59, 0, 0);
            61: return tap_bits(61, 60, 46, 45);
            62: return tap_bits(62, 61, 6, 5);
            63: return tap_bits(63, 62, 0, 0);
            64: return tap_bits(64, 63, 61, 60);
            default: return tap_bits(2, 1, 0, 0);
        endcase
    endfunction

    function automatic logic [63:0] lfsr_step(input logic [63:0] value, input int width);
        logic [63:0] keep;
        logic        fb;
        keep = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
        fb   = ^(value & lfsr_taps(width));
        return ((value << 1) | {63'd0, fb}) & keep;
    endfunction

endpackage

// File: rtl/io_dft_bist_misr.sv
// Multiple-input signature register: seeded on load, compacts masked feedback on enable.
module io_dft_bist_misr
    import generic_io_dft_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          func_clk,
    input  logic          func_rst_n,
    input  logic          load,
    input  logic [DW-1:0] seed,
    input  logic          en,
    input  logic [DW-1:0] data,
    input  logic [DW-1:0] mask,
    output logic [DW-1:0] misr
);

    always_ff @(posedge func_clk or negedge func_rst_n) begin
        if (!func_rst_n) begin
            misr <= '0;
        end else if (load) begin
            misr <= seed;
        end else if (en) begin
            misr <= DW'(lfsr_step(64'(misr), DW)) ^ (data & ~mask);
        end
    end

endmodule

// File: rtl/generic_io_dft_bist.sv
// IO loopback BIST: LFSR pattern onto selected lanes, MISR compaction of feedback, pass/fail.
// Optional mismatch counter built when GENERIC_IO_DFT_BIST_ERR_CNT_EN is defined.
//
// state | meaning
// IDLE  | functional path, waiting for bist_start
// SEED  | load LFSR, MISR, pattern counter, mask and expected signature
// RUN   | drive pattern on unmasked lanes, LFSR steps, counter decrements
// DRAIN | wait FB_DLY cycles for in-flight feedback to reach the MISR
// CHECK | compare signature against expected value
// DONE  | hold result until bist_en falls or a new bist_start
module generic_io_dft_bist
    import generic_io_dft_pkg::*;
#(
    parameter int          CH_NUM        = 4,
    parameter int          CH_DW         = 8,
    parameter int          PAT_CNT_W     = 16,
    parameter int          FB_DLY        = 2,
    parameter logic [63:0] LFSR_TOG_INIT = 64'hAAAA_AAAA_AAAA_AAAA,
    localparam int         DW            = CH_NUM * CH_DW
) (
    input  logic                 func_clk,
    input  logic                 func_rst_n,
    input  logic                 bist_en,
    input  logic                 bist_start,
    input  logic [CH_NUM-1:0]    bist_ch_mask,
    input  logic [PAT_CNT_W-1:0] bist_pat_len,
    input  logic [DW-1:0]        bist_lfsr_seed,
    input  logic [DW-1:0]        bist_misr_seed,
    input  logic [DW-1:0]        bist_misr_exp,
    input  logic [DW-1:0]        func_datap_in,
    output logic [DW-1:0]        func_datap_out,
    input  logic [DW-1:0]        func_datap_io_fb,
    output logic                 bist_busy,
    output logic                 bist_done,
    output logic                 bist_pass,
    output logic [DW-1:0]        bist_misr,
    output logic [15:0]          bist_err_cnt
);

    localparam logic [2:0]    DLY_LD = 3'((FB_DLY > 0) ? FB_DLY - 1 : 0);
    localparam logic [DW-1:0] TOG    = LFSR_TOG_INIT[DW-1:0];

    bist_state_e          state_q, state_d;
    logic [PAT_CNT_W-1:0] cnt_q;
    logic [2:0]           dly_q;
    logic [DW-1:0]        lfsr_q, exp_q, mask_bits;
    logic [CH_NUM-1:0]    mask_q;
    logic                 pass_q, cmp_en, sig_ok, run_now;

    assign run_now = (state_q == ST_RUN);

    always_ff @(posedge func_clk or negedge func_rst_n) begin
        if (!func_rst_n) state_q <= ST_IDLE;
        else             state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bist_start) state_d = ST_SEED;
            ST_SEED: begin
                if (bist_pat_len != '0) state_d = ST_RUN;
                else                    state_d = (FB_DLY == 0) ? ST_CHECK : ST_DRAIN;
            end
            ST_RUN:   if (cnt_q == PAT_CNT_W'(1)) state_d = (FB_DLY == 0) ? ST_CHECK : ST_DRAIN;
            ST_DRAIN: if (dly_q == 3'd0) state_d = ST_CHECK;
            ST_CHECK: state_d = ST_DONE;
            ST_DONE:  if (bist_start) state_d = ST_SEED;
            default:  state_d = ST_IDLE;
        endcase
        if (!bist_en) state_d = ST_IDLE;
    end

    always_ff @(posedge func_clk or negedge func_rst_n) begin
        if (!func_rst_n) begin
            cnt_q  <= '0;
            dly_q  <= DLY_LD;
            lfsr_q <= TOG;
            mask_q <= '0;
            exp_q  <= '0;
            pass_q <= 1'b0;
        end else begin
            case (state_q)
                ST_SEED: begin
                    cnt_q  <= bist_pat_len;
                    lfsr_q <= bist_lfsr_seed ^ TOG;
                    mask_q <= bist_ch_mask;
                    exp_q  <= bist_misr_exp;
                end
                ST_RUN: begin
                    cnt_q  <= cnt_q - PAT_CNT_W'(1);
                    lfsr_q <= DW'(lfsr_step(64'(lfsr_q), DW));
                end
                default: ;
            endcase
            dly_q  <= (state_q == ST_DRAIN) ? dly_q - 3'd1 : DLY_LD;
            pass_q <= (state_q == ST_CHECK) ? sig_ok : ((state_q == ST_DONE) ? pass_q : 1'b0);
        end
    end

    always_comb begin
        mask_bits = '0;
        for (int l = 0; l < CH_NUM; l++) begin
            mask_bits[l*CH_DW +: CH_DW] = {CH_DW{mask_q[l]}};
        end
    end

    assign func_datap_out = run_now ? ((lfsr_q & ~mask_bits) | (func_datap_in & mask_bits))
                                    : func_datap_in;

    // Compaction enable is the RUN flag delayed to line up with the IO feedback.
    generate
        if (FB_DLY == 0) begin : g_vld_direct
            assign cmp_en = run_now;
        end else begin : g_vld_pipe
            logic [FB_DLY-1:0] vld_pipe;
            always_ff @(posedge func_clk or negedge func_rst_n) begin
                if (!func_rst_n)  vld_pipe <= '0;
                else if (!bist_en) vld_pipe <= '0;
                else              vld_pipe <= FB_DLY'({vld_pipe, run_now});
            end
            assign cmp_en = vld_pipe[FB_DLY-1];
        end
    endgenerate

    io_dft_bist_misr #(.DW(DW)) u_misr (
        .func_clk   (func_clk),
        .func_rst_n (func_rst_n),
        .load       (state_q == ST_SEED),
        .seed       (bist_misr_seed),
        .en         (cmp_en),
        .data       (func_datap_io_fb),
        .mask       (mask_bits),
        .misr       (bist_misr)
    );

`ifdef GENERIC_IO_DFT_BIST_ERR_CNT_EN
    logic [DW-1:0] exp_word;
    logic [15:0]   err_q;
    logic          mis;

    generate
        if (FB_DLY == 0) begin : g_exp_direct
            assign exp_word = lfsr_q;
        end else begin : g_exp_pipe
            logic [DW-1:0] lfsr_dly [FB_DLY];
            always_ff @(posedge func_clk or negedge func_rst_n) begin
                if (!func_rst_n) begin
                    for (int i = 0; i < FB_DLY; i++) lfsr_dly[i] <= '0;
                end else begin
                    lfsr_dly[0] <= lfsr_q;
                    for (int i = 1; i < FB_DLY; i++) lfsr_dly[i] <= lfsr_dly[i-1];
                end
            end
            assign exp_word = lfsr_dly[FB_DLY-1];
        end
    endgenerate

    assign mis = cmp_en && (((func_datap_io_fb ^ exp_word) & ~mask_bits) != '0);

    always_ff @(posedge func_clk or negedge func_rst_n) begin
        if (!func_rst_n)                      err_q <= '0;
        else if (state_q == ST_SEED)          err_q <= '0;
        else if (mis && (err_q != 16'hFFFF))  err_q <= err_q + 16'd1;
    end

    assign bist_err_cnt = err_q;
    assign sig_ok       = (bist_misr == exp_q) && (err_q == '0);
`else
    assign bist_err_cnt = '0;
    assign sig_ok       = (bist_misr == exp_q);
`endif

    assign bist_busy = (state_q == ST_SEED) || (state_q == ST_RUN) ||
                       (state_q == ST_DRAIN) || (state_q == ST_CHECK);
    assign bist_done = (state_q == ST_DONE);
    assign bist_pass = pass_q && (state_q == ST_DONE);

endmodule

// File: tb/tb_generic_io_dft_bist.sv
// Scoreboard bench for generic_io_dft_bist: directed runs over a 2-cycle loopback wire.
`timescale 1ns/1ps
module tb_generic_io_dft_bist;

    logic        func_clk = 1'b0;
    logic        func_rst_n, bist_en, bist_start;
    logic [3:0]  bist_ch_mask;
    logic [15:0] bist_pat_len;
    logic [31:0] bist_lfsr_seed, bist_misr_seed, bist_misr_exp;
    logic [31:0] func_datap_in, func_datap_out, func_datap_io_fb;
    logic        bist_busy, bist_done, bist_pass;
    logic [31:0] bist_misr;
    logic [15:0] bist_err_cnt;

    always #5 func_clk = ~func_clk;

    generic_io_dft_bist #(
        .CH_NUM(4), .CH_DW(8), .PAT_CNT_W(16), .FB_DLY(2),
        .LFSR_TOG_INIT(64'hAAAA_AAAA_AAAA_AAAA)
    ) dut (
        .func_clk         (func_clk),
        .func_rst_n       (func_rst_n),
        .bist_en          (bist_en),
        .bist_start       (bist_start),
        .bist_ch_mask     (bist_ch_mask),
        .bist_pat_len     (bist_pat_len),
        .bist_lfsr_seed   (bist_lfsr_seed),
        .bist_misr_seed   (bist_misr_seed),
        .bist_misr_exp    (bist_misr_exp),
        .func_datap_in    (func_datap_in),
        .func_datap_out   (func_datap_out),
        .func_datap_io_fb (func_datap_io_fb),
        .bist_busy        (bist_busy),
        .bist_done        (bist_done),
        .bist_pass        (bist_pass),
        .bist_misr        (bist_misr),
        .bist_err_cnt     (bist_err_cnt)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    always @(posedge func_clk) cyc <= cyc + 1;

    // Two-register IO loopback with an optional bit-flip injected on the way in.
    logic [31:0] corr_now = '0;
    logic [31:0] fb1 = '0;
    logic [31:0] fb2 = '0;
    always @(posedge func_clk) begin
        fb1 <= func_datap_out ^ corr_now;
        fb2 <= fb1;
    end
    assign func_datap_io_fb = fb2;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic [31:0] misr;
        logic        pass;
        logic [15:0] err;
        int          cyc;
    } exp_t;
    exp_t sb_q[$];

    logic done_d = 1'b0;
    always @(negedge func_clk) begin
        exp_t e;
        if (bist_done && !done_d) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
                e = sb_q.pop_front();
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
                chk("misr", bist_misr, e.misr);
                chk("pass", bist_pass, e.pass);
                chk("err_cnt", bist_err_cnt, e.err);
            end
        end
        done_d <= bist_done;
    end

    function automatic logic [31:0] step(input logic [31:0] x);
        return {x[30:0], x[31] ^ x[21] ^ x[1] ^ x[0]};
    endfunction

    function automatic logic [31:0] lane_bits(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    function automatic logic [31:0] model_sig(input int len, input logic [31:0] ls, input logic [31:0] ms,
                                              input logic [3:0] mask, input logic [31:0] corr,
                                              input int c_from, input int c_n);
        logic [31:0] lf, sig, mb, c;
        mb = lane_bits(mask);
        lf = ls ^ 32'hAAAA_AAAA;
        sig = ms;
        for (int k = 0; k < len; k++) begin
            c = (k >= c_from && k < c_from + c_n) ? corr : 32'h0;
            sig = step(sig) ^ ((lf ^ c) & ~mb);
            lf = step(lf);
        end
        return sig;
    endfunction

    function automatic int model_err(input int len, input logic [3:0] mask, input logic [31:0] corr,
                                     input int c_from, input int c_n);
        int e;
        e = 0;
`ifdef GENERIC_IO_DFT_BIST_ERR_CNT_EN
        for (int k = 0; k < len; k++)
            if (k >= c_from && k < c_from + c_n && ((corr & ~lane_bits(mask)) != 0)) e++;
`endif
        return e;
    endfunction

    task automatic run_bist(input int len, input logic [31:0] ls, input logic [31:0] ms,
                            input logic [31:0] exp_sig, input logic [3:0] mask,
                            input logic [31:0] corr, input int c_from, input int c_n);
        logic [31:0] sig, mb, pat, want;
        int   err, c0, k;
        exp_t e;
        sig = model_sig(len, ls, ms, mask, corr, c_from, c_n);
        err = model_err(len, mask, corr, c_from, c_n);
        mb  = lane_bits(mask);
        pat = ls ^ 32'hAAAA_AAAA;
        @(posedge func_clk); #1;
        bist_pat_len = 16'(len); bist_lfsr_seed = ls; bist_misr_seed = ms;
        bist_misr_exp = exp_sig; bist_ch_mask = mask; bist_start = 1'b1;
        c0 = cyc;
        e.misr = sig; e.pass = (sig == exp_sig) && (err == 0); e.err = 16'(err); e.cyc = c0 + len + 5;
        sb_q.push_back(e);
        for (int j = 1; j <= len + 5; j++) begin
            @(posedge func_clk); #1;
            bist_start = 1'b0;
            k = j - 2;
            corr_now = (k >= 0 && k < len && k >= c_from && k < c_from + c_n) ? corr : 32'h0;
            @(negedge func_clk);
            if (j >= 2 && j <= len + 1) begin
                want = (pat & ~mb) | (func_datap_in & mb);
                pat = step(pat);
            end else begin
                want = func_datap_in;
            end
            chk("datap_out", func_datap_out, want);
            chk("busy", bist_busy, (j <= len + 4));
        end
        @(posedge func_clk); #1;
        corr_now = '0;
    endtask

    logic [31:0] s_ref, p;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        func_rst_n = 1'b0; bist_en = 1'b0; bist_start = 1'b0; bist_ch_mask = '0;
        bist_pat_len = '0; bist_lfsr_seed = '0; bist_misr_seed = '0; bist_misr_exp = '0;
        func_datap_in = 32'h1234_5678;
        repeat (3) @(posedge func_clk);
        @(negedge func_clk);
        chk("rst_out", func_datap_out, 32'h1234_5678);
        chk("rst_busy", bist_busy, 0);
        chk("rst_done", bist_done, 0);
        chk("rst_pass", bist_pass, 0);
        chk("rst_misr", bist_misr, 0);
        chk("rst_err", bist_err_cnt, 0);
        @(posedge func_clk); #1;
        func_rst_n = 1'b1; bist_en = 1'b1;

        s_ref = model_sig(16, 32'h0, 32'h1, 4'b0000, 32'h0, 0, 0);
        run_bist(16, 32'h0, 32'h1, 32'h0, 4'b0000, 32'h0, 0, 0);
        run_bist(16, 32'h0, 32'h1, s_ref, 4'b0000, 32'h0, 0, 0);

        // Result must hold in DONE, then clear when bist_en falls.
        @(negedge func_clk);
        chk("hold_done", bist_done, 1);
        chk("hold_pass", bist_pass, 1);
        chk("hold_misr", bist_misr, s_ref);
        @(posedge func_clk); #1; bist_en = 1'b0;
        @(posedge func_clk); #1;
        @(negedge func_clk);
        chk("en_off_done", bist_done, 0);
        chk("en_off_pass", bist_pass, 0);
        chk("en_off_busy", bist_busy, 0);
        bist_en = 1'b1;

        run_bist(16, 32'h0, 32'h1, s_ref, 4'b0000, 32'h0000_0020, 4, 3);
        run_bist(16, 32'h0, 32'h1, model_sig(16, 32'h0, 32'h1, 4'b0010, 32'h0, 0, 0),
                 4'b0010, 32'h0000_FF00, 2, 4);
        run_bist(0, 32'h0, 32'h1, 32'h1, 4'b0000, 32'h0, 0, 0);
        run_bist(5, 32'hDEAD_BEEF, 32'h0F0F_0F0F,
                 model_sig(5, 32'hDEAD_BEEF, 32'h0F0F_0F0F, 4'b1001, 32'h0, 0, 0),
                 4'b1001, 32'h0, 0, 0);

        // Abort in RUN; a second start mid-run must be ignored.
        bist_pat_len = 16'd16; bist_lfsr_seed = 32'h0; bist_misr_seed = 32'h1;
        bist_misr_exp = s_ref; bist_ch_mask = 4'b0000;
        @(posedge func_clk); #1; bist_start = 1'b1;
        @(posedge func_clk); #1; bist_start = 1'b0;
        @(posedge func_clk); #1;
        @(posedge func_clk); #1;
        @(posedge func_clk); #1; bist_start = 1'b1;
        @(posedge func_clk); #1; bist_start = 1'b0;
        p = step(step(step(32'hAAAA_AAAA)));
        @(negedge func_clk);
        chk("ignored_start", func_datap_out, p);
        @(posedge func_clk); #1; bist_en = 1'b0;
        @(negedge func_clk);
        chk("abort_same_cycle", func_datap_out, step(p));
        @(posedge func_clk); #1;
        @(negedge func_clk);
        chk("abort_busy", bist_busy, 0);
        chk("abort_done", bist_done, 0);
        chk("abort_pass", bist_pass, 0);
        chk("abort_out", func_datap_out, 32'h1234_5678);
        @(posedge func_clk); #1; bist_en = 1'b1;

        // Reset asserted in the middle of DRAIN (cycle 18 of a 16-word run).
        @(posedge func_clk); #1; bist_start = 1'b1;
        for (int j = 1; j <= 18; j++) begin
            @(posedge func_clk); #1;
            bist_start = 1'b0;
        end
        #2 func_rst_n = 1'b0;
        #1;
        chk("midrst_busy", bist_busy, 0);
        chk("midrst_done", bist_done, 0);
        chk("midrst_pass", bist_pass, 0);
        chk("midrst_misr", bist_misr, 0);
        chk("midrst_err", bist_err_cnt, 0);
        chk("midrst_out", func_datap_out, 32'h1234_5678);
        @(posedge func_clk); #1; func_rst_n = 1'b1;
        run_bist(16, 32'h0, 32'h1, s_ref, 4'b0000, 32'h0, 0, 0);

        repeat (3) @(posedge func_clk);
        chk("scoreboard_drained", 64'(sb_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
